// File: rtl/otter_lsu_pkg.sv
// rtl/otter_lsu_pkg.sv - shared types and constants for the OTTER load/store alignment unit
package otter_lsu_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD_LO,
        S_CAP_LO,
        S_WR_LO,
        S_RD_HI,
        S_CAP_HI,
        S_WR_HI,
        S_RESP
    } lsu_state_t;

    localparam logic [1:0]  SZ_B = 2'd0;
    localparam logic [1:0]  SZ_H = 2'd1;
    localparam logic [1:0]  SZ_W = 2'd2;

    localparam logic [31:0] IO_BASE_DEFAULT = 32'h1100_0000;

endpackage

// File: rtl/otter_lsu_if.sv
// rtl/otter_lsu_if.sv - CPU request side and word memory port of the alignment unit
interface otter_lsu_if;
    logic        LSU_START;
    logic        LSU_WE;
    logic [31:0] LSU_ADDR;
    logic [31:0] LSU_WDATA;
    logic [1:0]  LSU_SIZE;
    logic        LSU_SIGN;
    logic        LSU_BUSY;
    logic        LSU_DONE;
    logic [31:0] LSU_RDATA;
    logic        LSU_ERR;
    logic [31:0] MEM_ADDR2;
    logic [31:0] MEM_DIN2;
    logic        MEM_WRITE2;
    logic        MEM_READ2;
    logic [1:0]  MEM_SIZE;
    logic        MEM_SIGN;
    logic [31:0] MEM_DOUT2;

    modport slave (
        input  LSU_START, LSU_WE, LSU_ADDR, LSU_WDATA, LSU_SIZE, LSU_SIGN, MEM_DOUT2,
        output LSU_BUSY, LSU_DONE, LSU_RDATA, LSU_ERR,
               MEM_ADDR2, MEM_DIN2, MEM_WRITE2, MEM_READ2, MEM_SIZE, MEM_SIGN
    );

    modport master (
        output LSU_START, LSU_WE, LSU_ADDR, LSU_WDATA, LSU_SIZE, LSU_SIGN, MEM_DOUT2,
        input  LSU_BUSY, LSU_DONE, LSU_RDATA, LSU_ERR,
               MEM_ADDR2, MEM_DIN2, MEM_WRITE2, MEM_READ2, MEM_SIZE, MEM_SIGN
    );
endinterface

// File: rtl/otter_lsu_lane.sv
// rtl/otter_lsu_lane.sv - byte-lane extract/extend and store merge over the {hi,lo} word pair
module otter_lsu_lane
    import otter_lsu_pkg::*;
(
    input  logic [31:0] hi_i,
    input  logic [31:0] lo_i,
    input  logic [31:0] wdata_i,
    input  logic [1:0]  off_i,
    input  logic [1:0]  size_i,
    input  logic        sign_i,
    output logic [31:0] rdata_o,
    output logic [31:0] merged_lo_o,
    output logic [31:0] merged_hi_o
);
    logic [63:0] pair;
    logic [31:0] shifted;
    logic [7:0]  byte_mask;
    logic [63:0] bit_mask;
    logic [63:0] wdata_sh;
    logic [63:0] merged;

    always_comb begin
        pair    = {hi_i, lo_i};
        shifted = 32'(pair >> {off_i, 3'b000});
        case (size_i)
            SZ_B:    rdata_o = sign_i ? {24'h0, shifted[7:0]}
                                      : {{24{shifted[7]}}, shifted[7:0]};
            SZ_H:    rdata_o = sign_i ? {16'h0, shifted[15:0]}
                                      : {{16{shifted[15]}}, shifted[15:0]};
            default: rdata_o = shifted;
        endcase
    end

    // Byte enables slide across both words so a split store can merge each half independently.
    always_comb begin
        case (size_i)
            SZ_B:    byte_mask = 8'h01 << off_i;
            SZ_H:    byte_mask = 8'h03 << off_i;
            default: byte_mask = 8'h0F << off_i;
        endcase
        bit_mask = 64'h0;
        for (int b = 0; b < 8; b++) begin
            bit_mask[8*b +: 8] = {8{byte_mask[b]}};
        end
        wdata_sh    = {32'h0, wdata_i} << {off_i, 3'b000};
        merged      = (pair & ~bit_mask) | (wdata_sh & bit_mask);
        merged_lo_o = merged[31:0];
        merged_hi_o = merged[63:32];
    end
endmodule

// File: rtl/otter_lsu_align.sv
// rtl/otter_lsu_align.sv - OTTER load/store alignment unit; LSU_MISALIGN_EN enables word-crossing splits
module otter_lsu_align
    import otter_lsu_pkg::*;
#(
    parameter logic [31:0] IO_BASE = IO_BASE_DEFAULT
) (
    input  logic         CLK,
    input  logic         RST,
    otter_lsu_if.slave   bus
);
`ifdef LSU_MISALIGN_EN
    localparam logic MISALIGN_EN = 1'b1;
`else
    localparam logic MISALIGN_EN = 1'b0;
`endif

    lsu_state_t  state_q, state_d;
    logic [31:0] addr_q, wdata_q, lo_q, hi_q, rdata_q;
    logic [1:0]  size_q;
    logic        sign_q, we_q, err_q;
`ifdef LSU_MISALIGN_EN
    logic        span_q;
`endif

    logic [1:0]  req_off;
    logic [2:0]  req_n;
    logic        req_span, req_io, req_err;
    logic [31:0] req_lo, req_hi, lo_addr, hi_addr;
    logic [31:0] lane_lo, lane_hi, lane_rdata, merged_lo, merged_hi;

    always_comb begin
        req_off = bus.LSU_ADDR[1:0];
        case (bus.LSU_SIZE)
            SZ_B:    req_n = 3'd1;
            SZ_H:    req_n = 3'd2;
            default: req_n = 3'd4;
        endcase
        req_span = ({1'b0, req_off} + req_n) > 3'd4;
        req_lo   = {bus.LSU_ADDR[31:2], 2'b00};
        req_hi   = req_lo + 32'd4;
        req_io   = bus.LSU_ADDR >= IO_BASE;
        req_err  = (bus.LSU_SIZE == 2'd3)
                || (req_io && (req_off != 2'd0 || bus.LSU_SIZE != SZ_W))
                || (req_span && req_hi >= IO_BASE)
                || (req_span && !MISALIGN_EN);
    end

    assign lo_addr = {addr_q[31:2], 2'b00};
    assign hi_addr = lo_addr + 32'd4;
    assign lane_lo = (state_q == S_CAP_LO) ? bus.MEM_DOUT2 : lo_q;
    assign lane_hi = (state_q == S_CAP_HI) ? bus.MEM_DOUT2 : hi_q;

    otter_lsu_lane u_lane (
        .hi_i        (lane_hi),
        .lo_i        (lane_lo),
        .wdata_i     (wdata_q),
        .off_i       (addr_q[1:0]),
        .size_i      (size_q),
        .sign_i      (sign_q),
        .rdata_o     (lane_rdata),
        .merged_lo_o (merged_lo),
        .merged_hi_o (merged_hi)
    );

    always_ff @(posedge CLK) begin
        if (RST) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            addr_q  <= '0;
            wdata_q <= '0;
            size_q  <= '0;
            sign_q  <= 1'b0;
            we_q    <= 1'b0;
            err_q   <= 1'b0;
            lo_q    <= '0;
            hi_q    <= '0;
            rdata_q <= '0;
`ifdef LSU_MISALIGN_EN
            span_q  <= 1'b0;
`endif
        end else begin
            case (state_q)
                S_IDLE: if (bus.LSU_START) begin
                    addr_q  <= bus.LSU_ADDR;
                    wdata_q <= bus.LSU_WDATA;
                    size_q  <= bus.LSU_SIZE;
                    sign_q  <= bus.LSU_SIGN;
                    we_q    <= bus.LSU_WE;
                    err_q   <= req_err;
`ifdef LSU_MISALIGN_EN
                    span_q  <= req_span;
`endif
                end
                S_CAP_LO: begin
                    lo_q <= bus.MEM_DOUT2;
`ifdef LSU_MISALIGN_EN
                    if (!we_q && !span_q) rdata_q <= lane_rdata;
`else
                    if (!we_q) rdata_q <= lane_rdata;
`endif
                end
`ifdef LSU_MISALIGN_EN
                S_CAP_HI: begin
                    hi_q <= bus.MEM_DOUT2;
                    if (!we_q) rdata_q <= lane_rdata;
                end
`endif
                default: ;
            endcase
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (bus.LSU_START) begin
                if (req_err)
                    state_d = S_RESP;
                else if (bus.LSU_WE && bus.LSU_SIZE == SZ_W && req_off == 2'd0)
                    state_d = S_WR_LO;
                else
                    state_d = S_RD_LO;
            end
            S_RD_LO:  state_d = S_CAP_LO;
`ifdef LSU_MISALIGN_EN
            S_CAP_LO: state_d = we_q ? S_WR_LO : (span_q ? S_RD_HI : S_RESP);
            S_WR_LO:  state_d = span_q ? S_RD_HI : S_RESP;
            S_RD_HI:  state_d = S_CAP_HI;
            S_CAP_HI: state_d = we_q ? S_WR_HI : S_RESP;
            S_WR_HI:  state_d = S_RESP;
`else
            S_CAP_LO: state_d = we_q ? S_WR_LO : S_RESP;
            S_WR_LO:  state_d = S_RESP;
`endif
            S_RESP:   state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    always_comb begin
        bus.MEM_ADDR2  = '0;
        bus.MEM_DIN2   = '0;
        bus.MEM_WRITE2 = 1'b0;
        bus.MEM_READ2  = 1'b0;
        bus.LSU_DONE   = 1'b0;
        bus.LSU_ERR    = 1'b0;
        case (state_q)
            S_RD_LO:  begin bus.MEM_ADDR2 = lo_addr; bus.MEM_READ2 = 1'b1; end
            S_CAP_LO: bus.MEM_ADDR2 = lo_addr;
            S_WR_LO:  begin bus.MEM_ADDR2 = lo_addr; bus.MEM_WRITE2 = 1'b1; bus.MEM_DIN2 = merged_lo; end
            S_RD_HI:  begin bus.MEM_ADDR2 = hi_addr; bus.MEM_READ2 = 1'b1; end
            S_CAP_HI: bus.MEM_ADDR2 = hi_addr;
            S_WR_HI:  begin bus.MEM_ADDR2 = hi_addr; bus.MEM_WRITE2 = 1'b1; bus.MEM_DIN2 = merged_hi; end
            S_RESP:   begin bus.LSU_DONE = 1'b1; bus.LSU_ERR = err_q; end
            default:  ;
        endcase
    end

    assign bus.LSU_BUSY  = (state_q != S_IDLE);
    assign bus.LSU_RDATA = rdata_q;
    assign bus.MEM_SIZE  = 2'd2;
    assign bus.MEM_SIGN  = 1'b0;
endmodule

// File: tb/tb_otter_lsu_align.sv
// tb/tb_otter_lsu_align.sv - directed bench for otter_lsu_align; expectations follow LSU_MISALIGN_EN
module tb_otter_lsu_align;
    logic CLK = 1'b0;
    logic RST;
    always #5 CLK = ~CLK;

    otter_lsu_if bus();

    otter_lsu_align dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    int total = 0;
    int bad   = 0;

    logic [31:0] mem [logic [31:0]];
    int          rd_cnt, wr_cnt, done_cnt;
    logic [31:0] rd_addr, wr_addr;

    // Word memory: read data appears the cycle after READ2, writes land at the strobe.
    always @(negedge CLK) begin
        if (bus.MEM_READ2) begin
            rd_cnt++;
            rd_addr = bus.MEM_ADDR2;
            bus.MEM_DOUT2 = mem.exists(bus.MEM_ADDR2) ? mem[bus.MEM_ADDR2] : 32'h0;
        end
        if (bus.MEM_WRITE2) begin
            wr_cnt++;
            wr_addr = bus.MEM_ADDR2;
            mem[bus.MEM_ADDR2] = bus.MEM_DIN2;
        end
        if (bus.LSU_DONE) done_cnt++;
    end

    task automatic run_op(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [1:0] size, input logic sign,
                          output int cyc, output logic [31:0] rdata, output logic err);
        @(negedge CLK);
        rd_cnt = 0; wr_cnt = 0; done_cnt = 0;
        rd_addr = 'x; wr_addr = 'x;
        bus.LSU_START = 1'b1; bus.LSU_WE = we; bus.LSU_ADDR = addr;
        bus.LSU_WDATA = wdata; bus.LSU_SIZE = size; bus.LSU_SIGN = sign;
        @(posedge CLK);
        #1 bus.LSU_START = 1'b0;
        cyc = -1; rdata = 'x; err = 1'bx;
        for (int k = 1; k <= 20; k++) begin
            @(negedge CLK);
            if (bus.LSU_DONE) begin
                cyc = k; rdata = bus.LSU_RDATA; err = bus.LSU_ERR;
                break;
            end
        end
        @(negedge CLK);
        #1;
    endtask

    task automatic test_reset();
        RST = 1'b1;
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        total++; if (bus.LSU_BUSY !== 1'b0 || bus.LSU_DONE !== 1'b0 || bus.LSU_ERR !== 1'b0) begin bad++; $display("FAIL reset_status busy=%b done=%b err=%b exp 0", bus.LSU_BUSY, bus.LSU_DONE, bus.LSU_ERR); end
        total++; if (bus.LSU_RDATA !== 32'h0 || bus.MEM_ADDR2 !== 32'h0 || bus.MEM_DIN2 !== 32'h0) begin bad++; $display("FAIL reset_data rdata=%h addr=%h din=%h exp 0", bus.LSU_RDATA, bus.MEM_ADDR2, bus.MEM_DIN2); end
        total++; if (bus.MEM_WRITE2 !== 1'b0 || bus.MEM_READ2 !== 1'b0) begin bad++; $display("FAIL reset_strobes wr=%b rd=%b exp 0", bus.MEM_WRITE2, bus.MEM_READ2); end
        total++; if (bus.MEM_SIZE !== 2'd2 || bus.MEM_SIGN !== 1'b0) begin bad++; $display("FAIL mem_const size=%0d sign=%b exp 2/0", bus.MEM_SIZE, bus.MEM_SIGN); end
        RST = 1'b0;
    endtask

    task automatic test_load_word();
        int c; logic [31:0] r; logic e;
        mem[32'h100] = 32'hDEAD_BEEF;
        run_op(1'b0, 32'h100, 32'h0, 2'd2, 1'b0, c, r, e);
        total++; if (c !== 3) begin bad++; $display("FAIL lw_done_cycle got=%0d exp=3", c); end
        total++; if (r !== 32'hDEAD_BEEF || e !== 1'b0) begin bad++; $display("FAIL lw_data got=%h err=%b exp=deadbeef err=0", r, e); end
        total++; if (rd_cnt !== 1 || rd_addr !== 32'h100 || wr_cnt !== 0) begin bad++; $display("FAIL lw_strobes rd=%0d @%h wr=%0d exp rd=1 @100 wr=0", rd_cnt, rd_addr, wr_cnt); end
        total++; if (done_cnt !== 1) begin bad++; $display("FAIL lw_done_pulses got=%0d exp=1", done_cnt); end
    endtask

    task automatic test_load_sub();
        int c; logic [31:0] r; logic e;
        mem[32'h100] = 32'h8012_3456;
        run_op(1'b0, 32'h103, 32'h0, 2'd0, 1'b0, c, r, e);
        total++; if (r !== 32'hFFFF_FF80 || c !== 3) begin bad++; $display("FAIL lb got=%h cyc=%0d exp=ffffff80 cyc=3", r, c); end
        run_op(1'b0, 32'h103, 32'h0, 2'd0, 1'b1, c, r, e);
        total++; if (r !== 32'h0000_0080) begin bad++; $display("FAIL lbu got=%h exp=00000080", r); end
        run_op(1'b0, 32'h102, 32'h0, 2'd1, 1'b0, c, r, e);
        total++; if (r !== 32'hFFFF_8012) begin bad++; $display("FAIL lh got=%h exp=ffff8012", r); end
        run_op(1'b0, 32'h100, 32'h0, 2'd1, 1'b1, c, r, e);
        total++; if (r !== 32'h0000_3456) begin bad++; $display("FAIL lhu got=%h exp=00003456", r); end
    endtask

    task automatic test_store_sub();
        int c; logic [31:0] r; logic e;
        mem[32'h100] = 32'h1122_3344;
        run_op(1'b1, 32'h102, 32'h0000_ABCD, 2'd1, 1'b0, c, r, e);
        total++; if (c !== 4 || e !== 1'b0) begin bad++; $display("FAIL sh_done got=%0d err=%b exp=4 err=0", c, e); end
        total++; if (rd_cnt !== 1 || wr_cnt !== 1 || wr_addr !== 32'h100) begin bad++; $display("FAIL sh_strobes rd=%0d wr=%0d @%h exp 1/1 @100", rd_cnt, wr_cnt, wr_addr); end
        total++; if (mem[32'h100] !== 32'hABCD_3344) begin bad++; $display("FAIL sh_merge got=%h exp=abcd3344", mem[32'h100]); end
        run_op(1'b1, 32'h101, 32'hFFFF_FFEE, 2'd0, 1'b0, c, r, e);
        total++; if (mem[32'h100] !== 32'hABCD_EE44) begin bad++; $display("FAIL sb_merge got=%h exp=abcdee44", mem[32'h100]); end
    endtask

    task automatic test_span();
        int c; logic [31:0] r; logic e;
        mem[32'h0FC] = 32'h4433_2211;
        mem[32'h100] = 32'h8877_6655;
        run_op(1'b0, 32'h0FE, 32'h0, 2'd2, 1'b0, c, r, e);
`ifdef LSU_MISALIGN_EN
        total++; if (r !== 32'h6655_4433 || e !== 1'b0 || c !== 5) begin bad++; $display("FAIL span_lw got=%h err=%b cyc=%0d exp=66554433 0 5", r, e, c); end
        total++; if (rd_cnt !== 2 || rd_addr !== 32'h100 || wr_cnt !== 0) begin bad++; $display("FAIL span_lw_strobes rd=%0d @%h wr=%0d exp 2 @100 0", rd_cnt, rd_addr, wr_cnt); end
        run_op(1'b0, 32'h0FF, 32'h0, 2'd1, 1'b0, c, r, e);
        total++; if (r !== 32'h0000_5544) begin bad++; $display("FAIL span_lh got=%h exp=00005544", r); end
        run_op(1'b1, 32'h0FE, 32'hA1B2_C3D4, 2'd2, 1'b0, c, r, e);
        total++; if (c !== 7 || wr_cnt !== 2 || rd_cnt !== 2) begin bad++; $display("FAIL span_sw_seq cyc=%0d wr=%0d rd=%0d exp 7 2 2", c, wr_cnt, rd_cnt); end
        total++; if (mem[32'h0FC] !== 32'hC3D4_2211 || mem[32'h100] !== 32'h8877_A1B2) begin bad++; $display("FAIL span_sw_merge lo=%h hi=%h exp c3d42211 8877a1b2", mem[32'h0FC], mem[32'h100]); end
`else
        total++; if (e !== 1'b1 || c !== 1) begin bad++; $display("FAIL span_lw_err err=%b cyc=%0d exp 1 1", e, c); end
        total++; if (rd_cnt !== 0 || wr_cnt !== 0) begin bad++; $display("FAIL span_lw_strobes rd=%0d wr=%0d exp 0 0", rd_cnt, wr_cnt); end
        run_op(1'b1, 32'h0FE, 32'hA1B2_C3D4, 2'd2, 1'b0, c, r, e);
        total++; if (e !== 1'b1 || wr_cnt !== 0 || mem[32'h0FC] !== 32'h4433_2211) begin bad++; $display("FAIL span_sw_err err=%b wr=%0d lo=%h exp 1 0 44332211", e, wr_cnt, mem[32'h0FC]); end
`endif
    endtask

    task automatic test_io();
        int c; logic [31:0] r; logic e;
        run_op(1'b1, 32'h1100_0004, 32'h1234_5678, 2'd2, 1'b0, c, r, e);
        total++; if (c !== 2 || wr_cnt !== 1 || rd_cnt !== 0 || e !== 1'b0) begin bad++; $display("FAIL io_sw cyc=%0d wr=%0d rd=%0d err=%b exp 2 1 0 0", c, wr_cnt, rd_cnt, e); end
        total++; if (mem[32'h1100_0004] !== 32'h1234_5678) begin bad++; $display("FAIL io_sw_data got=%h exp=12345678", mem[32'h1100_0004]); end
        run_op(1'b0, 32'h1100_0004, 32'h0, 2'd2, 1'b0, c, r, e);
        total++; if (r !== 32'h1234_5678 || c !== 3) begin bad++; $display("FAIL io_lw got=%h cyc=%0d exp=12345678 3", r, c); end
        run_op(1'b0, 32'h1100_0002, 32'h0, 2'd1, 1'b0, c, r, e);
        total++; if (e !== 1'b1 || c !== 1 || rd_cnt !== 0 || wr_cnt !== 0) begin bad++; $display("FAIL io_lh_err err=%b cyc=%0d rd=%0d wr=%0d exp 1 1 0 0", e, c, rd_cnt, wr_cnt); end
        run_op(1'b0, 32'h10FF_FFFE, 32'h0, 2'd2, 1'b0, c, r, e);
        total++; if (e !== 1'b1 || rd_cnt !== 0) begin bad++; $display("FAIL span_into_io err=%b rd=%0d exp 1 0", e, rd_cnt); end
        run_op(1'b0, 32'h100, 32'h0, 2'd3, 1'b0, c, r, e);
        total++; if (e !== 1'b1 || c !== 1 || rd_cnt !== 0) begin bad++; $display("FAIL size3_err err=%b cyc=%0d rd=%0d exp 1 1 0", e, c, rd_cnt); end
    endtask

    task automatic test_back_to_back();
        int c; logic [31:0] r; logic e; int seen;
        mem[32'h200] = 32'h1111_1111;
        mem[32'h300] = 32'h2222_2222;
        @(negedge CLK);
        rd_cnt = 0; wr_cnt = 0; done_cnt = 0;
        bus.LSU_START = 1'b1; bus.LSU_WE = 1'b0; bus.LSU_ADDR = 32'h200; bus.LSU_SIZE = 2'd2; bus.LSU_SIGN = 1'b0;
        @(posedge CLK);
        #1 bus.LSU_ADDR = 32'h300;
        @(posedge CLK);
        #1 bus.LSU_START = 1'b0;
        seen = 0; r = 'x;
        for (int k = 0; k < 20; k++) begin
            @(negedge CLK);
            if (bus.LSU_DONE) begin seen = 1; r = bus.LSU_RDATA; break; end
        end
        repeat (3) @(negedge CLK);
        #1;
        total++; if (seen !== 1 || r !== 32'h1111_1111) begin bad++; $display("FAIL busy_ignore done=%0d rdata=%h exp 1 11111111", seen, r); end
        total++; if (rd_cnt !== 1 || rd_addr !== 32'h200 || done_cnt !== 1) begin bad++; $display("FAIL busy_ignore_strobes rd=%0d @%h done=%0d exp 1 @200 1", rd_cnt, rd_addr, done_cnt); end
        run_op(1'b0, 32'h300, 32'h0, 2'd2, 1'b0, c, r, e);
        total++; if (r !== 32'h2222_2222 || c !== 3) begin bad++; $display("FAIL second_op got=%h cyc=%0d exp 22222222 3", r, c); end
    endtask

    task automatic test_reset_mid();
        mem[32'h400] = 32'hCAFE_BABE;
        @(negedge CLK);
        rd_cnt = 0; wr_cnt = 0; done_cnt = 0;
        bus.LSU_START = 1'b1; bus.LSU_WE = 1'b1; bus.LSU_ADDR = 32'h401;
        bus.LSU_WDATA = 32'h0000_0055; bus.LSU_SIZE = 2'd0; bus.LSU_SIGN = 1'b0;
        @(posedge CLK);
        #1 bus.LSU_START = 1'b0;
        @(posedge CLK);
        @(negedge CLK);
        total++; if (bus.LSU_BUSY !== 1'b1 || bus.MEM_READ2 !== 1'b0 || bus.MEM_ADDR2 !== 32'h400) begin bad++; $display("FAIL cap_lo_state busy=%b rd=%b addr=%h exp 1 0 400", bus.LSU_BUSY, bus.MEM_READ2, bus.MEM_ADDR2); end
        RST = 1'b1;
        @(negedge CLK);
        total++; if (bus.LSU_BUSY !== 1'b0 || bus.MEM_ADDR2 !== 32'h0 || bus.MEM_WRITE2 !== 1'b0 || bus.LSU_RDATA !== 32'h0) begin bad++; $display("FAIL rst_mid_outputs busy=%b addr=%h wr=%b rdata=%h exp 0", bus.LSU_BUSY, bus.MEM_ADDR2, bus.MEM_WRITE2, bus.LSU_RDATA); end
        RST = 1'b0;
        repeat (6) @(negedge CLK);
        #1;
        total++; if (wr_cnt !== 0 || done_cnt !== 0 || mem[32'h400] !== 32'hCAFE_BABE) begin bad++; $display("FAIL rst_mid_effects wr=%0d done=%0d mem=%h exp 0 0 cafebabe", wr_cnt, done_cnt, mem[32'h400]); end
    endtask

    initial begin
        bus.LSU_START = 1'b0; bus.LSU_WE = 1'b0; bus.LSU_ADDR = '0;
        bus.LSU_WDATA = '0; bus.LSU_SIZE = '0; bus.LSU_SIGN = 1'b0;
        rd_cnt = 0; wr_cnt = 0; done_cnt = 0;
        test_reset();
        test_load_word();
        test_load_sub();
        test_store_sub();
        test_span();
        test_io();
        test_back_to_back();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
